// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle sequencer: opcodes, FSM states,
// ALU operation selects and trap causes.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_IMEM_TO = 2'b10,
        CAUSE_DMEM_TO = 2'b11
    } cause_t;

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive ready-less wait cycles; expire flags the TIMEOUT-th wait.
// TIMEOUT of 0 disables expiry entirely.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
)(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic wait_cyc,
    output logic expire
);

    localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (wait_cyc && cnt != LIMIT)
            cnt <= cnt + 1'b1;
    end

    // cnt holds the number of waits already seen, so LIMIT means this is the last one
    assign expire = (TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory ready
// handshakes, wait watchdog, sticky trap and retired-instruction counter.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             alu_zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             branch,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state
);

    state_t  st, st_nx;
    cause_t  cause_q, cause_nx;
    alu_op_t aop;
    logic    waiting, expire, timer_clr;

    assign waiting   = (st == S_FETCH && !imem_ready) || (st == S_MEM && !dmem_ready);
    assign timer_clr = (st_nx != st);

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (clk),
        .rst      (reset),
        .clear    (timer_clr),
        .wait_cyc (waiting),
        .expire   (expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st      <= S_IDLE;
            cause_q <= CAUSE_NONE;
            instret <= '0;
        end else begin
            st      <= st_nx;
            cause_q <= cause_nx;
            if (retire)
                instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        st_nx      = st;
        cause_nx   = cause_q;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src    = 1'b0;
        aop        = ALU_ADD;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        branch     = 1'b0;
        retire     = 1'b0;
        trap       = 1'b0;
        case (st)
            S_IDLE: st_nx = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    st_nx    = S_DECODE;
                end else if (expire) begin
                    st_nx    = S_TRAP;
                    cause_nx = CAUSE_IMEM_TO;
                end
            end
            S_DECODE: begin
                if (is_legal(opcode)) begin
                    st_nx = S_EXEC;
                end else begin
                    st_nx    = S_TRAP;
                    cause_nx = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE: begin
                        aop   = ALU_FUNCT;
                        st_nx = S_WB;
                    end
                    OP_ADDI: begin
                        alu_src = 1'b1;
                        aop     = ALU_FUNCT;
                        st_nx   = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src = 1'b1;
                        st_nx   = S_MEM;
                    end
                    OP_BRANCH: begin
                        aop      = ALU_SUB;
                        branch   = 1'b1;
                        pc_write = alu_zero;
                        pc_src   = 1'b1;
                        retire   = 1'b1;
                        st_nx    = S_FETCH;
                    end
                    // opcode changed under us after DECODE: treat as illegal
                    default: begin
                        st_nx    = S_TRAP;
                        cause_nx = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM: begin
                alu_src   = 1'b1;
                mem_read  = (opcode == OP_LOAD);
                mem_write = (opcode == OP_STORE);
                if (dmem_ready) begin
                    if (opcode == OP_LOAD) begin
                        st_nx = S_WB;
                    end else begin
                        retire = 1'b1;
                        st_nx  = S_FETCH;
                    end
                end else if (expire) begin
                    st_nx    = S_TRAP;
                    cause_nx = CAUSE_DMEM_TO;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode == OP_LOAD);
                retire     = 1'b1;
                st_nx      = S_FETCH;
            end
            S_TRAP: trap = 1'b1;
            default: st_nx = S_IDLE;
        endcase
    end

    assign alu_op     = aop;
    assign trap_cause = cause_q;
    assign state      = st;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table-driven instructions, randomized
// instruction/wait streams against a latency/count model, and trap/reset sequences.
module tb_multicycle_ctrl;
    import riscv_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] opcode = 7'h0;
    logic       alu_zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic       imem_req, ir_write, pc_write, pc_src, alu_src;
    logic [1:0] alu_op;
    logic       mem_read, mem_write, mem_to_reg, reg_write, branch, retire, trap;
    logic [3:0] instret;
    logic [1:0] trap_cause;
    logic [2:0] state;
    logic [18:0] got;

    multicycle_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src(alu_src), .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .branch(branch), .retire(retire),
        .instret(instret), .trap(trap), .trap_cause(trap_cause), .state(state)
    );

    always #5 clk = ~clk;

    assign got = {imem_req, ir_write, pc_write, pc_src, alu_src, alu_op, mem_read, mem_write,
                  mem_to_reg, reg_write, branch, retire, trap, trap_cause, state};

    localparam logic [18:0] REQ = 19'h40000, IRW = 19'h20000, PCW = 19'h10000, PCS = 19'h08000;
    localparam logic [18:0] ASRC = 19'h04000, OP_FN = 19'h02000, OP_SB = 19'h01000;
    localparam logic [18:0] MRD = 19'h00800, MWR = 19'h00400, M2R = 19'h00200, RW = 19'h00100;
    localparam logic [18:0] BR = 19'h00080, RET = 19'h00040, TRP = 19'h00020;
    localparam logic [18:0] C_ILL = 19'h00008, C_IMEM = 19'h00010, C_DMEM = 19'h00018;

    typedef struct {
        logic [6:0] op;
        logic       z;
        int         fw;
        int         mw;
        int         lat;
    } vec_t;

    vec_t tbl[8];
    int   n_pass = 0, n_total = 0;
    int   model_ret = 0;

    function automatic logic [18:0] sv(state_t s);
        return 19'(s);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
        n_total++;
        if (g === e) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, g, e);
    endtask

    task automatic cyc(input logic ir, input logic dr, input logic z, input logic [18:0] ex,
                       input string nm);
        imem_ready = ir; dmem_ready = dr; alu_zero = z;
        @(negedge clk);
        chk(nm, 32'(got), 32'(ex));
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b1; #1;
        chk({nm, ":rst_out"}, 32'(got), 32'(sv(S_IDLE)));
        chk({nm, ":rst_instret"}, 32'(instret), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        model_ret = 0;
        cyc(rb(), rb(), rb(), sv(S_IDLE), {nm, ":idle"});
    endtask

    // Drives one instruction from its first FETCH cycle; checks every cycle and the latency.
    task automatic run_instr(input logic [6:0] op, input logic z, input int fw, input int mw,
                             input int exp_lat, input string nm);
        int lat = 0;
        opcode = op;
        for (int i = 0; i < fw; i++) begin
            cyc(1'b0, rb(), rb(), REQ | sv(S_FETCH), {nm, ":fwait"}); lat++;
        end
        cyc(1'b1, rb(), rb(), REQ | IRW | PCW | sv(S_FETCH), {nm, ":fetch"}); lat++;
        cyc(rb(), rb(), rb(), sv(S_DECODE), {nm, ":decode"}); lat++;
        case (op)
            OP_RTYPE, OP_ADDI: begin
                cyc(rb(), rb(), rb(), OP_FN | ((op == OP_ADDI) ? ASRC : 19'h0) | sv(S_EXEC),
                    {nm, ":exec"});
                cyc(rb(), rb(), rb(), RW | RET | sv(S_WB), {nm, ":wb"});
                lat += 2;
            end
            OP_LOAD: begin
                cyc(rb(), rb(), rb(), ASRC | sv(S_EXEC), {nm, ":exec"}); lat++;
                for (int i = 0; i < mw; i++) begin
                    cyc(rb(), 1'b0, rb(), ASRC | MRD | sv(S_MEM), {nm, ":mwait"}); lat++;
                end
                cyc(rb(), 1'b1, rb(), ASRC | MRD | sv(S_MEM), {nm, ":mem"});
                cyc(rb(), rb(), rb(), RW | M2R | RET | sv(S_WB), {nm, ":wb"});
                lat += 2;
            end
            OP_STORE: begin
                cyc(rb(), rb(), rb(), ASRC | sv(S_EXEC), {nm, ":exec"}); lat++;
                for (int i = 0; i < mw; i++) begin
                    cyc(rb(), 1'b0, rb(), ASRC | MWR | sv(S_MEM), {nm, ":mwait"}); lat++;
                end
                cyc(rb(), 1'b1, rb(), ASRC | MWR | RET | sv(S_MEM), {nm, ":mem"}); lat++;
            end
            default: begin
                cyc(rb(), rb(), z, OP_SB | BR | PCS | RET | (z ? PCW : 19'h0) | sv(S_EXEC),
                    {nm, ":exec"});
                lat++;
            end
        endcase
        chk({nm, ":latency"}, 32'(lat), 32'(exp_lat));
        model_ret = (model_ret + 1) % 16;
        chk({nm, ":instret"}, 32'(instret), 32'(model_ret));
    endtask

    initial begin
        tbl[0] = '{OP_RTYPE,  1'b0, 0, 0, 4};
        tbl[1] = '{OP_ADDI,   1'b0, 1, 0, 5};
        tbl[2] = '{OP_LOAD,   1'b0, 0, 3, 8};
        tbl[3] = '{OP_STORE,  1'b0, 2, 1, 7};
        tbl[4] = '{OP_BRANCH, 1'b1, 0, 0, 3};
        tbl[5] = '{OP_BRANCH, 1'b0, 0, 0, 3};
        tbl[6] = '{OP_LOAD,   1'b0, 3, 0, 8};
        tbl[7] = '{OP_STORE,  1'b0, 0, 3, 7};

        #1 reset = 1'b1;
        #1 do_reset("por");

        for (int i = 0; i < 8; i++)
            run_instr(tbl[i].op, tbl[i].z, tbl[i].fw, tbl[i].mw, tbl[i].lat,
                      $sformatf("tbl%0d", i));

        // reset mid-store: request must vanish immediately
        opcode = OP_STORE;
        cyc(1'b1, 1'b0, 1'b0, REQ | IRW | PCW | sv(S_FETCH), "swr:fetch");
        cyc(1'b0, 1'b0, 1'b0, sv(S_DECODE), "swr:decode");
        cyc(1'b0, 1'b0, 1'b0, ASRC | sv(S_EXEC), "swr:exec");
        dmem_ready = 1'b0;
        @(negedge clk);
        chk("swr:mem", 32'(got), 32'(ASRC | MWR | sv(S_MEM)));
        #1 do_reset("swr");

        for (int i = 0; i < 40; i++) begin
            logic [6:0] op;
            int fw, mw, lat, k;
            k  = $urandom_range(0, 4);
            op = (k == 0) ? OP_RTYPE : (k == 1) ? OP_ADDI : (k == 2) ? OP_LOAD :
                 (k == 3) ? OP_STORE : OP_BRANCH;
            fw = $urandom_range(0, 3);
            mw = $urandom_range(0, 3);
            lat = ((op == OP_BRANCH) ? 3 : (op == OP_LOAD) ? 5 : 4) + fw +
                  ((op == OP_LOAD || op == OP_STORE) ? mw : 0);
            run_instr(op, rb(), fw, mw, lat, $sformatf("rnd%0d", i));
        end

        opcode = 7'b1111111;
        cyc(1'b1, rb(), rb(), REQ | IRW | PCW | sv(S_FETCH), "ill:fetch");
        cyc(rb(), rb(), rb(), sv(S_DECODE), "ill:decode");
        for (int i = 0; i < 3; i++) cyc(rb(), rb(), rb(), TRP | C_ILL | sv(S_TRAP), "ill:trap");
        chk("ill:instret", 32'(instret), 32'(model_ret));
        do_reset("ill");

        opcode = OP_RTYPE;
        for (int i = 0; i < 4; i++) cyc(1'b0, rb(), rb(), REQ | sv(S_FETCH), "ito:wait");
        for (int i = 0; i < 2; i++) cyc(rb(), rb(), rb(), TRP | C_IMEM | sv(S_TRAP), "ito:trap");
        do_reset("ito");

        opcode = OP_LOAD;
        cyc(1'b1, rb(), rb(), REQ | IRW | PCW | sv(S_FETCH), "dto:fetch");
        cyc(rb(), rb(), rb(), sv(S_DECODE), "dto:decode");
        cyc(rb(), rb(), rb(), ASRC | sv(S_EXEC), "dto:exec");
        for (int i = 0; i < 4; i++) cyc(rb(), 1'b0, rb(), ASRC | MRD | sv(S_MEM), "dto:wait");
        for (int i = 0; i < 2; i++) cyc(rb(), rb(), rb(), TRP | C_DMEM | sv(S_TRAP), "dto:trap");
        do_reset("dto");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle sequencer for the RV32I core subset (R-type, addi, lw, sw, beq): steps the shared single ALU, register file and memory ports through FETCH/DECODE/EXEC/MEM/WB, one instruction at a time. Sits between the instruction register and the datapath; produces the same control set as the single-cycle decode (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp) but valid only in the correct phase. Adds instruction/data memory ready handshakes, a wait-timeout watchdog, a sticky trap and a retired-instruction counter.

## Interface
- TIMEOUT, 16, max cycles to wait for a memory ready; 0 disables the watchdog
- CNT_W, 32, width of instret counter
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and clears counters
- opcode  in  7  IR[6:0], stable from DECODE until next FETCH
- alu_zero  in  1  ALU zero flag, sampled in EXEC for beq
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data load valid / store accepted this cycle
- imem_req  out  1  instruction fetch request at PC
- ir_write  out  1  load IR from instruction memory
- pc_write  out  1  update PC
- pc_src  out  1  0: PC+4, 1: branch target (old_pc+imm, held by datapath)
- alu_src  out  1  0: rs2, 1: immediate
- alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded
- mem_read  out  1  data read request (held until dmem_ready)
- mem_write  out  1  data write request (held until dmem_ready)
- mem_to_reg  out  1  writeback source: 1 memory, 0 ALU
- reg_write  out  1  register file write strobe
- branch  out  1  EXEC of beq
- retire  out  1  one-cycle pulse on instruction completion
- instret  out  CNT_W  retired-instruction count, wraps to 0
- trap  out  1  sticky; core halted
- trap_cause  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout
- state  out  3  current state, debug

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Registered state; outputs combinational from state, opcode and ready (ir_write/pc_write in FETCH depend on imem_ready).
- IDLE: all outputs 0; → FETCH next cycle.
- FETCH: imem_req=1. On imem_ready: ir_write=1, pc_write=1, pc_src=0, → DECODE. Else stay.
- DECODE: opcode in {0110011, 0010011, 0000011, 0100011, 1100011} → EXEC; else → TRAP, cause 01. No strobes.
- EXEC: alu_src/alu_op per opcode (R: 0/10; addi: 1/10; lw, sw: 1/00; beq: 0/01). R, addi → WB; lw, sw → MEM; beq: branch=1, pc_write=alu_zero, pc_src=1, retire=1, → FETCH.
- MEM: alu_src=1, alu_op=00 held; lw: mem_read=1; sw: mem_write=1. On dmem_ready: lw → WB; sw → retire=1, → FETCH.
- WB: reg_write=1, mem_to_reg=1 for lw else 0; retire=1; → FETCH.
- All outputs not listed for a state are 0 (including mem_to_reg, branch).
- Watchdog: counter clears on state entry; increments each FETCH/MEM cycle without ready; at TIMEOUT consecutive waits → TRAP, cause 10 (FETCH) or 11 (MEM). ready on the TIMEOUT-th cycle wins.
- TRAP: all strobes 0; trap=1; trap_cause held; exits only by reset.
- instret increments on each retire; wraps 2^CNT_W-1 → 0.

## Timing
- Reset asserted: state=IDLE, all outputs 0, instret=0, trap_cause=00, immediately (asynchronous). Mid-operation reset abandons any pending request; memory must tolerate dropped req.
- Zero-wait latencies (FETCH to retire, inclusive): beq 3, R/addi/sw 4, lw 5 cycles; each wait cycle adds one.
- Request held steady until ready; ready without request is ignored.
- retire and next imem_req are in adjacent cycles, never the same cycle.

## Structure
- Package riscv_ctrl_pkg: opcode constants, state encodings, ALUOp encodings, trap cause codes.
- One sub-module, mem_wait_timer: clearable saturating counter with TIMEOUT compare and disable-at-0.

## Test plan
- Reset release, opcode 0110011, both ready tied 1 → states IDLE,FETCH,DECODE,EXEC,WB; reg_write only in WB; retire after 4 cycles; instret=1.
- lw with dmem_ready low 3 cycles → mem_read held 4 cycles, WB with mem_to_reg=1, 8 cycles FETCH to retire.
- beq with alu_zero=1 then 0 → pc_write=1,pc_src=1 in first EXEC; pc_write=0 in second; both retire.
- opcode 1111111 → TRAP after DECODE, trap_cause=01, no strobes until reset.
- TIMEOUT=4, imem_ready held 0 → TRAP after 4 FETCH cycles, cause 10; ready on cycle 4 instead → DECODE.
- Reset pulsed during MEM of sw → mem_write drops same cycle, state=IDLE, instret=0.
